// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit
// Program-counter unit at the front of the fetch stage. cur drives the
// instruction-memory address; control inputs come from decode / branch
// resolution. Supports sequential advance, absolute and relative jumps,
// call/return through a small circular return-address stack (RAS), a
// pipeline stall, and wrap/misalign signalling.
//
// Ports
//   clk      in   1         rising-edge clock
//   rst      in   1         synchronous reset, active-high
//   stall    in   1         hold PC and RAS; jmp/call/ret dropped
//   jmp      in   1         take jump this cycle
//   rel      in   1         with jmp: 1 = cur+diff, 0 = nxt
//   call     in   1         with jmp: push return address cur+STEP
//   ret      in   1         pop RAS top into cur
//   nxt      in   XLEN      absolute jump target
//   diff     in   XLEN      relative offset, two's complement
//   cur      out  XLEN      current PC (registered)
//   ras_cnt  out  CNT_W     valid RAS entries (registered)
//   ras_ovf  out  1         one-cycle pulse: push overwrote oldest entry
//   ras_unf  out  1         one-cycle pulse: ret on empty RAS
//   mis      out  1         cur not aligned to STEP (combinational)
//
// Request priority per edge: rst > stall > ret > jmp (incl. call) > sequential.
// -----------------------------------------------------------------------------
module pc_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int unsigned     STEP      = 4,
  parameter int unsigned     RAS_DEPTH = 4,
  localparam int unsigned    CNT_W     = $clog2(RAS_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             jmp,
  input  logic             rel,
  input  logic             call,
  input  logic             ret,
  input  logic [XLEN-1:0]  nxt,
  input  logic [XLEN-1:0]  diff,
  output logic [XLEN-1:0]  cur,
  output logic [CNT_W-1:0] ras_cnt,
  output logic             ras_ovf,
  output logic             ras_unf,
  output logic             mis
);

  localparam int unsigned     PTR_W  = $clog2(RAS_DEPTH);
  localparam logic [XLEN-1:0] STEP_V = XLEN'(STEP);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]  cur_q, cur_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] top_q, top_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             push;
  logic [XLEN-1:0]  seq_pc;

  // Storage has no reset: contents are meaningless while cnt_q is zero.
  logic [XLEN-1:0]  ras_mem_q [RAS_DEPTH];

  assign seq_pc = cur_q + STEP_V;

  always_comb begin
    cur_d = cur_q;
    cnt_d = cnt_q;
    top_d = top_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    push  = 1'b0;
    if (stall) begin
      // Hold everything; requests are dropped and flags fall to 0.
    end else if (ret) begin
      if (cnt_q != '0) begin
        cur_d = ras_mem_q[top_q];
        top_d = top_q - PTR_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        cur_d = seq_pc;
        unf_d = 1'b1;
      end
    end else if (jmp) begin
      cur_d = rel ? (cur_q + diff) : nxt;
      if (call) begin
        // When full, top+1 is the oldest slot, so the push overwrites it.
        push  = 1'b1;
        top_d = top_q + PTR_W'(1);
        if (cnt_q == FULL) ovf_d = 1'b1;
        else               cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cur_d = seq_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q <= RESET_VEC;
      cnt_q <= '0;
      top_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cur_q <= cur_d;
      cnt_q <= cnt_d;
      top_q <= top_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Return address is the pre-jump cur+STEP.
  always_ff @(posedge clk) begin
    if (!rst && push) ras_mem_q[top_d] <= seq_pc;
  end

  assign cur     = cur_q;
  assign ras_cnt = cnt_q;
  assign ras_ovf = ovf_q;
  assign ras_unf = unf_q;
  assign mis     = |(cur_q & (STEP_V - XLEN'(1)));

endmodule

// File: tb/tb_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_unit
// Directed vectors for pc_unit with default parameters (XLEN 32, RESET_VEC 0,
// STEP 4, RAS_DEPTH 4). Each table row is applied for one clock edge and the
// registered outputs are compared #1 after that edge. A hand-written sequence
// follows for overflow-then-stall and reset in the middle of a call chain.
// -----------------------------------------------------------------------------
module tb_pc_unit;

  typedef struct {
    logic        rst, stall, jmp, rel, call, ret;
    logic [31:0] nxt, diff;
    logic [31:0] e_cur;
    logic [2:0]  e_cnt;
    logic        e_ovf, e_unf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, stall, jmp, rel, call, ret;
  logic [31:0] nxt, diff;
  logic [31:0] cur;
  logic [2:0]  ras_cnt;
  logic        ras_ovf, ras_unf, mis;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .jmp(jmp), .rel(rel),
    .call(call), .ret(ret), .nxt(nxt), .diff(diff), .cur(cur),
    .ras_cnt(ras_cnt), .ras_ovf(ras_ovf), .ras_unf(ras_unf), .mis(mis)
  );

  // clock
  always #5 clk = ~clk;

  function automatic vec_t v(input logic r, s, j, rl, c, rt,
                             input logic [31:0] n, d, ec,
                             input int ecnt, input logic eo, eu);
    vec_t x;
    x.rst = r; x.stall = s; x.jmp = j; x.rel = rl; x.call = c; x.ret = rt;
    x.nxt = n; x.diff = d; x.e_cur = ec; x.e_cnt = 3'(ecnt);
    x.e_ovf = eo; x.e_unf = eu;
    return x;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // driver: apply one set of inputs across one rising edge
  task automatic drive(input logic r, s, j, rl, c, rt,
                       input logic [31:0] n, d);
    rst = r; stall = s; jmp = j; rel = rl; call = c; ret = rt;
    nxt = n; diff = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input int idx, input logic [31:0] ec,
                           input logic [2:0] ecnt, input logic eo, eu);
    chk("cur", idx, cur, ec);
    chk("ras_cnt", idx, 32'(ras_cnt), 32'(ecnt));
    chk("ras_ovf", idx, 32'(ras_ovf), 32'(eo));
    chk("ras_unf", idx, 32'(ras_unf), 32'(eu));
    chk("mis", idx, 32'(mis), 32'(|ec[1:0]));
  endtask

  initial begin
    logic [31:0] pc_m;
    logic [31:0] ret_m [$];

    rst = 1'b1; stall = 0; jmp = 0; rel = 0; call = 0; ret = 0;
    nxt = '0; diff = '0;

    //             rst stl jmp rel cal ret  nxt           diff          e_cur        cnt ovf unf
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h4,        0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h8,        0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'hC,        0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h10,       0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h14,       0, 0, 0));
    // absolute jump, then sequential from target
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 32'h1000,     32'h0,        32'h1000,     0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h1004,     0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h1008,     0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h100C,     0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h1010,     0, 0, 0));
    // relative backward jump: 0x1010 - 0x14
    vecs.push_back(v(0, 0, 1, 1, 0, 0, 32'h0,        32'hFFFF_FFEC, 32'hFFC,     0, 0, 0));
    // call from 0x100, 3 cycles, ret to 0x104
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 32'h100,      32'h0,        32'h100,      0, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 1, 0, 32'h2000,     32'h0,        32'h2000,     1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h2004,     1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h2008,     1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h200C,     1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h104,      0, 0, 0));
    // sequential wrap at top of address space
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 32'hFFFF_FFF8, 32'h0,       32'hFFFF_FFF8, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'hFFFF_FFFC, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 0));
    // call without jmp is ignored
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 32'h5000,     32'h0,        32'h4,        0, 0, 0));
    // five nested calls: A1=0x8 A2=0x104 A3=0x204 A4=0x304 A5=0x404
    vecs.push_back(v(0, 0, 1, 0, 1, 0, 32'h100,      32'h0,        32'h100,      1, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 1, 0, 32'h200,      32'h0,        32'h200,      2, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 1, 0, 32'h300,      32'h0,        32'h300,      3, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 1, 0, 32'h400,      32'h0,        32'h400,      4, 0, 0));
    vecs.push_back(v(0, 0, 1, 1, 1, 0, 32'h0,        32'h100,      32'h500,      4, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h404,      3, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h304,      2, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h204,      1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h104,      0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h108,      0, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h10C,      0, 0, 0));
    // stall with jmp held 3 cycles: dropped, not queued
    vecs.push_back(v(0, 1, 1, 0, 0, 0, 32'h3000,     32'h0,        32'h10C,      0, 0, 0));
    vecs.push_back(v(0, 1, 1, 0, 0, 0, 32'h3000,     32'h0,        32'h10C,      0, 0, 0));
    vecs.push_back(v(0, 1, 1, 0, 0, 0, 32'h3000,     32'h0,        32'h10C,      0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h110,      0, 0, 0));
    // stall holds RAS; ret+jmp+call: ret wins, no push
    vecs.push_back(v(0, 0, 1, 0, 1, 0, 32'h600,      32'h0,        32'h600,      1, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 0, 1, 32'h0,        32'h0,        32'h600,      1, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 1, 1, 32'h7000,     32'h0,        32'h114,      0, 0, 0));
    // reset with ras_cnt=3 and a call pending
    vecs.push_back(v(0, 0, 1, 0, 1, 0, 32'h800,      32'h0,        32'h800,      1, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 1, 0, 32'h900,      32'h0,        32'h900,      2, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 1, 0, 32'hA00,      32'h0,        32'hA00,      3, 0, 0));
    vecs.push_back(v(1, 0, 1, 0, 1, 0, 32'hB00,      32'h0,        32'h0,        0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h4,        0, 0, 1));
    // misaligned targets are taken, mis follows cur
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 32'h1002,     32'h0,        32'h1002,     0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h1006,     0, 0, 0));
    vecs.push_back(v(0, 0, 1, 1, 0, 0, 32'h0,        32'h2,        32'h1008,     0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].jmp, vecs[i].rel,
            vecs[i].call, vecs[i].ret, vecs[i].nxt, vecs[i].diff);
      check_all(i, vecs[i].e_cur, vecs[i].e_cnt, vecs[i].e_ovf, vecs[i].e_unf);
    end

    // Overflow then stall: flag must drop while stalled, RAS held, then the
    // newest return address comes back first. Model keeps the last 4 entries.
    pc_m = 32'h1008;
    for (int i = 0; i < 5; i++) begin
      ret_m.push_back(pc_m + 32'd4);
      if (ret_m.size() > 4) void'(ret_m.pop_front());
      pc_m = 32'h4000 + 32'(i) * 32'h100;
      drive(0, 0, 1, 0, 1, 0, pc_m, 32'h0);
      check_all(100 + i, pc_m, (i < 4) ? 3'(i + 1) : 3'd4, i == 4, 1'b0);
    end
    drive(0, 1, 0, 0, 0, 1, 32'h0, 32'h0);
    check_all(105, pc_m, 3'd4, 1'b0, 1'b0);
    pc_m = ret_m.pop_back();
    drive(0, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    check_all(106, pc_m, 3'd3, 1'b0, 1'b0);
    pc_m = ret_m.pop_back();
    drive(0, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    check_all(107, pc_m, 3'd2, 1'b0, 1'b0);
    // reset mid return chain
    drive(1, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    check_all(108, 32'h0, 3'd0, 1'b0, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    check_all(109, 32'h4, 3'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
